// File: rtl/nibble_add_pkg.sv
// Shared definitions for the nibble-serial add arbiter.
//   NIBBLE_W      : width of the shared adder slice (one nibble)
//   IDLE/ADD/DONE : controller state encoding
package nibble_add_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/nibble_add_arbiter_add4_cin.sv
// add4_cin: 4-bit ripple adder with carry-in, built from half adders.
// Each bit uses two half adders whose carries are ORed (they can never
// both be 1, so OR is exact).
//   a, b : nibble operands
//   cin  : carry into bit 0
//   s    : nibble sum
//   cout : carry out of bit 3
module add4_cin
    import nibble_add_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    logic [NIBBLE_W:0]   c;
    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] pc;

    assign c[0] = cin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
        // first half adder: a + b
        assign p[i]   = a[i] ^ b[i];
        assign g[i]   = a[i] & b[i];
        // second half adder: partial sum + incoming carry
        assign s[i]   = p[i] ^ c[i];
        assign pc[i]  = p[i] & c[i];
        assign c[i+1] = g[i] | pc[i];
    end

    assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_add_arbiter.sv
// nibble_add_arbiter: serves two requesters with one shared 4-bit adder.
// Round-robin arbitration under contention, operands latched at accept,
// then one nibble added per clock (LSB first) with a registered carry.
//   clk, rst         : clock, asynchronous active-high reset
//   req0/req1        : requests
//   a0,b0 / a1,b1    : operands of requester 0 / 1
//   gnt0/gnt1        : one-cycle accept pulse
//   busy             : accept edge until done falls
//   done             : one-cycle result-valid pulse
//   owner            : requester of the current/last operation
//   sum, cout        : WIDTH-bit result and carry out of the MSB
module nibble_add_arbiter
    import nibble_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             owner,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    logic [1:0]          state;
    logic [IDX_W-1:0]    idx;
    logic                carry;
    logic                prio;
    logic                win;
    logic                accept;
    logic [WIDTH-1:0]    a_lat;
    logic [WIDTH-1:0]    b_lat;
    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W-1:0] nib_s;
    logic                nib_c;

    // A lone requester always wins; prio only breaks a tie.
    always_comb begin
        win    = 1'b0;
        accept = 1'b0;
        if (state == IDLE && (req0 || req1)) begin
            accept = 1'b1;
            win    = (req0 && req1) ? prio : req1;
        end
    end

    assign nib_a = a_lat[idx*NIBBLE_W +: NIBBLE_W];
    assign nib_b = b_lat[idx*NIBBLE_W +: NIBBLE_W];

    add4_cin u_add4 (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry),
        .s    (nib_s),
        .cout (nib_c)
    );

    // Operand latches: datapath only, captured at the accept edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_lat <= win ? a1 : a0;
            b_lat <= win ? b1 : b0;
        end
    end

    // Controller and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            prio  <= 1'b0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            owner <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner <= win;
                        gnt0  <= ~win;
                        gnt1  <= win;
                        busy  <= 1'b1;
                        sum   <= '0;
                        idx   <= '0;
                        carry <= 1'b0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    sum[idx*NIBBLE_W +: NIBBLE_W] <= nib_s;
                    carry <= nib_c;
                    idx   <= idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        cout  <= nib_c;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // hand the next tie to the requester not just served
                    prio  <= ~owner;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_add_arbiter.sv
// Bench for nibble_add_arbiter: directed scenarios plus randomized
// operations, compared against a plain-arithmetic reference model.
module tb_nibble_add_arbiter;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0, req1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic             gnt0, gnt1, busy, done, owner, cout;
    logic [WIDTH-1:0] sum;

    int n_chk  = 0;
    int n_fail = 0;
    bit m_prio = 1'b0;

    always #5 clk = ~clk;

    nibble_add_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .req1  (req1),
        .a0    (a0),
        .b0    (b0),
        .a1    (a1),
        .b1    (b1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .busy  (busy),
        .done  (done),
        .owner (owner),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt0"},  32'(gnt0),  0);
        check({tag, "_gnt1"},  32'(gnt1),  0);
        check({tag, "_busy"},  32'(busy),  0);
        check({tag, "_done"},  32'(done),  0);
        check({tag, "_owner"}, 32'(owner), 0);
        check({tag, "_cout"},  32'(cout),  0);
        check({tag, "_sum"},   32'(sum),   0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_prio = 1'b0;
    endtask

    // One complete operation, called at a negedge with the DUT in IDLE.
    // The winner drops its request after gnt (unless hold) and its
    // operands are then scribbled to prove only latched values are used.
    task automatic do_op(input bit r0, input bit r1,
                         input logic [WIDTH-1:0] x0, input logic [WIDTH-1:0] y0,
                         input logic [WIDTH-1:0] x1, input logic [WIDTH-1:0] y1,
                         input bit hold);
        bit               w;
        logic [WIDTH:0]   tot;
        int               cyc;
        a0 = x0; b0 = y0; a1 = x1; b1 = y1;
        req0 = r0; req1 = r1;
        w   = (r0 && r1) ? m_prio : r1;
        tot = w ? ({1'b0, x1} + {1'b0, y1}) : ({1'b0, x0} + {1'b0, y0});

        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(gnt0 || gnt1) && cyc < 20);
        check("gnt_wait", 32'(cyc), 1);
        check("gnt0", 32'(gnt0), 32'(!w));
        check("gnt1", 32'(gnt1), 32'(w));
        check("busy_on", 32'(busy), 1);

        if (!hold) begin
            if (w) begin
                req1 = 1'b0; a1 = 16'hAAAA; b1 = 16'($urandom);
            end else begin
                req0 = 1'b0; a0 = 16'hAAAA; b0 = 16'($urandom);
            end
        end

        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("gnt_pulse", 32'({gnt0, gnt1}), 0);
        end while (!done && cyc < 20);
        check("done_lat", 32'(cyc), 32'(NIB));
        check("sum", 32'(sum), 32'(tot[WIDTH-1:0]));
        check("cout", 32'(cout), 32'(tot[WIDTH]));
        check("owner", 32'(owner), 32'(w));
        check("busy_done", 32'(busy), 1);

        @(negedge clk);
        check("done_fall", 32'(done), 0);
        check("busy_fall", 32'(busy), 0);
        check("sum_hold", 32'(sum), 32'(tot[WIDTH-1:0]));
        m_prio = !w;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        m_prio = 1'b0;
        @(negedge clk);

        // single request and full carry ripple
        do_op(1'b1, 1'b0, 16'h1234, 16'h0FCD, 16'h0000, 16'h0000, 1'b0);
        check("t1_sum_const", 32'(sum), 32'h2201);
        do_op(1'b0, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 1'b0);
        check("t2_sum_const", 32'(sum), 32'h0000);
        check("t2_cout_const", 32'(cout), 1);

        // lone requesters against prio
        do_op(1'b1, 1'b0, 16'h0101, 16'h0202, 16'h0, 16'h0, 1'b0);
        do_op(1'b1, 1'b0, 16'h7FFF, 16'h8001, 16'h0, 16'h0, 1'b0);
        do_op(1'b0, 1'b1, 16'h0, 16'h0, 16'h4321, 16'h1111, 1'b0);

        // contention after reset: order 0,1,0,1 at 6-clock spacing
        pulse_reset();
        for (int k = 0; k < 4; k++) begin
            do_op(1'b1, 1'b1, 16'h1111, 16'h2222, 16'hF000, 16'h1000, 1'b1);
            check("rr_order", 32'(owner), 32'(k % 2));
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);

        // reset during the second ADD cycle
        a0 = 16'h5555; b0 = 16'h5555; req0 = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!gnt0 && cyc < 20);
        check("mid_gnt", 32'(gnt0), 1);
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        m_prio = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("midrst_no_done", 32'(done), 0);
        end
        do_op(1'b1, 1'b0, 16'h0008, 16'h0008, 16'h0, 16'h0, 1'b0);
        check("t6_sum_const", 32'(sum), 32'h0010);

        // randomized operations
        for (int k = 0; k < 24; k++) begin
            int sel;
            req0 = 1'b0; req1 = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            sel = int'($urandom_range(1, 3));
            do_op(sel[0], sel[1], 16'($urandom), 16'($urandom),
                  16'($urandom), 16'($urandom), 1'b0);
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_add_arbiter.md
# nibble_add_arbiter

Shared-adder controller that serves two requesters with one 4-bit ripple adder (built from half adders). It arbitrates round-robin between the requesters and latches the winner's WIDTH-bit operands. It then sequences the adder one nibble per clock, LSB nibble first, registering the inter-nibble carry. It returns the WIDTH-bit sum, carry-out and owner tag with a one-cycle done pulse. It sits between lab-level requesters and the 4-bit adder datapath, so wide additions need no wide adder.

## Interface
- WIDTH, 16, operand/sum width; must be a multiple of 4 and at least 4; NIB = WIDTH/4 nibble steps.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  request from requester 0 / 1.
- a0, b0 / a1, b1  in  WIDTH  operands; must be stable while the matching req is high.
- gnt0 / gnt1  out  1  one-cycle pulse: operands accepted.
- busy  out  1  high from the accept edge until done falls.
- done  out  1  one-cycle pulse: sum, cout and owner are valid.
- owner  out  1  index of the requester served by the current or last operation.
- sum  out  WIDTH  result, built nibble by nibble; holds after done.
- cout  out  1  carry out of the MSB nibble.

## Operation
- States: IDLE, ADD, DONE.
- IDLE, no req: remain in IDLE.
- IDLE, exactly one req high: accept that requester.
- IDLE, both req high: accept the requester selected by pointer prio.
- On accept:
  - latch a/b of the winner and set owner;
  - pulse gnt of the winner;
  - clear sum, set idx=0, carry=0;
  - go to ADD.
- ADD, each cycle:
  - {c, s} = a_lat[idx*4+:4] + b_lat[idx*4+:4] + carry;
  - sum[idx*4+:4] <= s; carry <= c; idx <= idx+1;
  - at idx==NIB-1, go to DONE and set cout <= c.
- DONE: assert done for one cycle; set prio to the requester not just served; go to IDLE.
- Round-robin holds only under contention. A lone requester is served immediately regardless of prio.
- Requesters drop req after seeing gnt. A req still high in IDLE after done counts as a new request.
- Arithmetic is unsigned modulo 2^WIDTH; cout is the true carry out of bit WIDTH-1.
- Reset, including mid-operation: abort the operation, go to IDLE.
  - gnt0, gnt1, busy, done, owner, cout, sum: all 0.
  - idx = 0, carry = 0.
  - prio = 0, so requester 0 wins the first contention.

## Timing
- Accept happens at edge E0 (state IDLE with a req sampled high). gnt and busy are high for the cycle after E0.
- ADD occupies NIB cycles. done rises at E0+NIB and falls at E0+NIB+1, together with busy.
- For WIDTH=16, done rises 4 clocks after gnt rises.
- The earliest next accept is edge E0+NIB+2, so throughput is one operation per NIB+2 clocks.
- sum, cout and owner change only after an accept or a reset. They are stable from done until the next accept.
- req changes during ADD or DONE are ignored. Operands are sampled only at the accept edge.

## Structure
- Shared package nibble_add_pkg:
  - state encoding localparams: IDLE, ADD, DONE;
  - NIBBLE_W = 4.
- One sub-module, add4_cin: 4-bit adder with carry-in and carry-out, built from half adders plus OR gates.
- Controller, operand latches, idx counter, carry register and prio pointer live in nibble_add_arbiter.

## Test plan
- Single request: req0 with a0=0x1234, b0=0x0FCD → gnt0 pulse; done 4 clocks later; sum=0x2201, cout=0, owner=0.
- Full carry ripple: req1 with a1=0xFFFF, b1=0x0001 → sum=0x0000, cout=1, owner=1; carry propagates through all 4 nibbles.
- Contention after reset: req0 and req1 held high continuously → grant order 0,1,0,1. Each done is followed by the other's gnt at the earliest accept edge (6-clock spacing).
- Lone requester against prio: serve req0, so prio=1; then only req1 and later only req0 → each is granted in the first IDLE cycle it is high.
- Operand hold: change a0 to 0xAAAA during ADD → result still reflects the latched operands.
- Reset mid-operation: assert rst during the second ADD cycle → all outputs 0 immediately, no done pulse. After release, req0 with 0x0008+0x0008 → sum=0x0010, cout=0.
